// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the packet-aware round-robin stream arbiter.
package axi_arb_pkg;

    localparam int unsigned MAX_PORTS    = 16;
    localparam int unsigned MAX_ID_WIDTH = 4;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                    found;
        logic [MAX_ID_WIDTH-1:0] idx;
    } rr_pick_t;

    // Width of a port index; a single bit even for two ports.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

    // First requester found searching upward from (last+1) mod n, wrapping once.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_PORTS-1:0]    req,
        input logic [MAX_ID_WIDTH-1:0] last,
        input int unsigned             n
    );
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        for (int unsigned k = 1; k <= MAX_PORTS; k++) begin
            cand = (32'(last) + k) % n;
            if (k <= n && !res.found && req[cand[MAX_ID_WIDTH-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[MAX_ID_WIDTH-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_slice.sv
// Full register slice: registered out_* and registered in_ready, with a
// skid entry that absorbs the beat accepted in the cycle out_ready drops.
module axi_slice #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  in_hs;

    assign in_hs = in_valid & in_ready;

    // Main/skid register update; in_ready drops once the skid entry is occupied.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else begin
            if (out_ready || !out_valid) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= in_hs;
                    if (in_hs) begin
                        out_data <= in_data;
                    end
                end
                in_ready <= 1'b1;
            end else begin
                if (in_hs) begin
                    skid_valid <= 1'b1;
                    skid_data  <= in_data;
                end
                in_ready <= !(skid_valid || in_hs);
            end
        end
    end

endmodule

// File: rtl/axi_rr_arbiter.sv
// Packet-aware round-robin arbiter merging NUM_PORTS valid/ready streams into
// one registered stream tagged with the source port ID.
module axi_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter  int unsigned NUM_PORTS  = 4,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned ID_WIDTH   = id_width(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_PORTS-1:0]             port_en,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_PORTS-1:0]             in_last,
    input  logic [NUM_PORTS-1:0]             in_valid,
    output logic [NUM_PORTS-1:0]             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_last,
    output logic [ID_WIDTH-1:0]              out_id,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int unsigned BEAT_WIDTH = DATA_WIDTH + 1 + ID_WIDTH;

    arb_state_t             state;
    logic [ID_WIDTH-1:0]    grant;
    logic [ID_WIDTH-1:0]    last_grant;
    logic [MAX_PORTS-1:0]   eligible;
    rr_pick_t               pick;

    logic [DATA_WIDTH-1:0]  port_data [NUM_PORTS];
    logic                   sel_valid;
    logic                   sel_last;
    logic                   slice_in_valid;
    logic                   slice_in_ready;
    logic [BEAT_WIDTH-1:0]  slice_in_beat;
    logic [BEAT_WIDTH-1:0]  slice_out_beat;
    logic                   handshake;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port_data
        assign port_data[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign eligible = MAX_PORTS'(in_valid & port_en);
    assign pick     = rr_pick(eligible, MAX_ID_WIDTH'(last_grant), NUM_PORTS);

    // Input mux for the granted port and ready steering back to it.
    always_comb begin
        sel_valid      = in_valid[grant];
        sel_last       = in_last[grant];
        slice_in_valid = (state == XFER) && sel_valid;
        slice_in_beat  = {grant, sel_last, port_data[grant]};
        in_ready       = '0;
        if (state == XFER) begin
            in_ready[grant] = slice_in_ready;
        end
    end

    assign handshake = slice_in_valid & slice_in_ready;

    // Arbitration FSM: pick in ARB, hold the grant until the last beat is accepted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ARB;
            grant      <= '0;
            last_grant <= ID_WIDTH'(NUM_PORTS - 1);
        end else begin
            case (state)
                ARB: begin
                    if (pick.found) begin
                        grant      <= ID_WIDTH'(pick.idx);
                        last_grant <= ID_WIDTH'(pick.idx);
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (handshake && sel_last) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    axi_slice #(
        .DATA_WIDTH (BEAT_WIDTH)
    ) u_slice (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (slice_in_beat),
        .in_valid  (slice_in_valid),
        .in_ready  (slice_in_ready),
        .out_data  (slice_out_beat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_id   = slice_out_beat[BEAT_WIDTH-1 -: ID_WIDTH];
    assign out_last = slice_out_beat[DATA_WIDTH];
    assign out_data = slice_out_beat[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Scoreboard bench for axi_rr_arbiter: per-port expected beat queues, packet
// order predicted from the round-robin rule over the enabled set.
module tb_axi_rr_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NP-1:0]     port_en;
    logic [NP*DW-1:0]  in_data;
    logic [NP-1:0]     in_last;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_ready;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [IW-1:0]     out_id;
    logic              out_valid;
    logic              out_ready;

    axi_rr_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .port_en   (port_en),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_id    (out_id),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            gap;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    beat_t port_q [NP][$];
    exp_t  exp_q  [NP][$];
    int    gap_cnt    [NP];
    bit    gap_loaded [NP];
    bit    hs         [NP];

    int n_tests = 0;
    int n_fail  = 0;

    bit          bp_en   = 1'b0;
    bit          rr_chk  = 1'b0;
    bit          gap_chk = 1'b0;
    bit          lat_chk = 1'b0;
    logic [NP-1:0] rr_mask = '1;
    int          rr_prev = NP - 1;
    int          lat_start = 0;
    int          last_end_cyc = -1;
    bit          mon_in_pkt = 1'b0;
    int          mon_id = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int next_in_mask(input int prev, input logic [NP-1:0] mask);
        for (int k = 1; k <= NP; k++) begin
            if (mask[(prev + k) % NP]) return (prev + k) % NP;
        end
        return -1;
    endfunction

    function automatic bit pending(input logic [NP-1:0] which);
        for (int i = 0; i < NP; i++) begin
            if (which[i] && (port_q[i].size() != 0 || exp_q[i].size() != 0)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push_beat(input int port, input logic [DW-1:0] data, input logic last, input int gap);
        beat_t b;
        exp_t  e;
        b.data = data; b.last = last; b.gap = gap;
        e.data = data; e.last = last;
        port_q[port].push_back(b);
        exp_q[port].push_back(e);
    endtask

    // One clock: sample handshakes before the edge, drive new inputs just after it.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NP; i++) hs[i] = in_valid[i] & in_ready[i];
        @(posedge clk);
        #1;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int i = 0; i < NP; i++) begin
            if (hs[i]) begin
                if (port_q[i].size() != 0) port_q[i].delete(0);
                in_valid[i]   = 1'b0;
                gap_loaded[i] = 1'b0;
            end
            if (!in_valid[i] && port_q[i].size() != 0) begin
                if (!gap_loaded[i]) begin
                    gap_cnt[i]    = port_q[i][0].gap;
                    gap_loaded[i] = 1'b1;
                end
                if (gap_cnt[i] == 0) begin
                    in_valid[i]            = 1'b1;
                    in_last[i]             = port_q[i][0].last;
                    in_data[i*DW +: DW]    = port_q[i][0].data;
                end else begin
                    gap_cnt[i]--;
                end
            end
        end
    endtask

    task automatic drain(input logic [NP-1:0] which, input int budget, input string name);
        int t;
        t = 0;
        while (pending(which) && t < budget) begin
            step();
            t++;
        end
        check({name, "_drained"}, 64'(pending(which)), 64'd0);
    endtask

    task automatic check_idle(input string name);
        check({name, "_out_valid"}, 64'(out_valid), 64'd0);
        check({name, "_in_ready"},  64'(in_ready),  64'd0);
        check({name, "_out_data"},  64'(out_data),  64'd0);
        check({name, "_out_last"},  64'(out_last),  64'd0);
        check({name, "_out_id"},    64'(out_id),    64'd0);
    endtask

    // Monitor: pops the expected beat for out_id on every output handshake.
    initial begin
        logic [DW-1:0] pd;
        logic          pl;
        logic [IW-1:0] pi;
        bit            prev_stall;
        exp_t          e;
        int            id;
        prev_stall = 1'b0;
        pd = '0; pl = 1'b0; pi = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                mon_in_pkt = 1'b0;
                prev_stall = 1'b0;
                rr_prev    = NP - 1;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_held", 64'(out_valid), 64'd1);
                    check("stall_beat_held", 64'({out_id, out_last, out_data}), 64'({pi, pl, pd}));
                end
                if (out_valid && out_ready) begin
                    id = int'(out_id);
                    if (mon_in_pkt) begin
                        check("pkt_lock_id", 64'(id), 64'(mon_id));
                    end else begin
                        if (rr_chk) check("rr_order", 64'(id), 64'(next_in_mask(rr_prev, rr_mask)));
                        if (gap_chk && last_end_cyc >= 0) check("pkt_gap", 64'(cyc - last_end_cyc), 64'd2);
                        if (lat_chk) begin
                            check("first_beat_latency", 64'(cyc - lat_start), 64'd2);
                            lat_chk = 1'b0;
                        end
                        rr_prev = id;
                    end
                    check("beat_expected", 64'(exp_q[id].size() != 0), 64'd1);
                    if (exp_q[id].size() != 0) begin
                        e = exp_q[id].pop_front();
                        check("beat_data", 64'(out_data), 64'(e.data));
                        check("beat_last", 64'(out_last), 64'(e.last));
                    end
                    mon_in_pkt = !out_last;
                    mon_id     = id;
                    if (out_last) last_end_cyc = cyc;
                end
                prev_stall = out_valid && !out_ready;
                pd = out_data; pl = out_last; pi = out_id;
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int total;
        int port;
        int len;
        int t;

        rstn = 1'b0; port_en = '1; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
        for (int i = 0; i < NP; i++) begin
            gap_loaded[i] = 1'b0;
            gap_cnt[i]    = 0;
            hs[i]         = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_idle("reset");

        // Single 3-beat packet on port 2 with fixed latency.
        push_beat(2, 32'hA0, 1'b0, 0);
        push_beat(2, 32'hA1, 1'b0, 0);
        push_beat(2, 32'hA2, 1'b1, 0);
        step();
        lat_start = cyc;
        lat_chk   = 1'b1;
        drain(4'b0100, 50, "basic");
        check("basic_latency_seen", 64'(lat_chk), 64'd0);

        // All ports streaming 2-beat packets: strict rotation, one idle cycle between.
        last_end_cyc = -1; gap_chk = 1'b1; rr_chk = 1'b1; rr_mask = 4'hF;
        for (int p = 0; p < 16; p++) begin
            for (int q = 0; q < NP; q++) begin
                push_beat(q, 32'(q * 256 + p * 2),     1'b0, 0);
                push_beat(q, 32'(q * 256 + p * 2 + 1), 1'b1, 0);
            end
        end
        drain(4'hF, 2000, "fairness");
        gap_chk = 1'b0; rr_chk = 1'b0;

        // Port 1 stalls mid-packet while port 3 keeps requesting.
        push_beat(1, 32'h100, 1'b0, 0);
        push_beat(1, 32'h101, 1'b0, 5);
        push_beat(1, 32'h102, 1'b1, 0);
        for (int p = 0; p < 2; p++) begin
            push_beat(3, 32'(32'h300 + p * 2),     1'b0, 0);
            push_beat(3, 32'(32'h300 + p * 2 + 1), 1'b1, 0);
        end
        drain(4'b1010, 200, "lock");

        // Mask: only ports 1 and 3 may win.
        port_en = 4'b1010; rr_mask = 4'b1010; rr_chk = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int q = 0; q < NP; q++) begin
                push_beat(q, 32'(32'h1000 + q * 16 + p * 2),     1'b0, 0);
                push_beat(q, 32'(32'h1000 + q * 16 + p * 2 + 1), 1'b1, 0);
            end
        end
        drain(4'b1010, 500, "mask");
        rr_chk = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("mask_idle_out_valid", 64'(out_valid), 64'd0);
        check("mask_idle_in_ready",  64'(in_ready),  64'd0);

        // Release ports 0/2, then reset in the middle of a packet.
        port_en = '1;
        t = 0;
        while (!mon_in_pkt && t < 100) begin
            step();
            t++;
        end
        check("reached_mid_packet", 64'(mon_in_pkt), 64'd1);
        rstn = 1'b0;
        in_valid = '0;
        in_last  = '0;
        for (int i = 0; i < NP; i++) begin
            port_q[i].delete();
            exp_q[i].delete();
            gap_loaded[i] = 1'b0;
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_idle("mid_reset");

        // After reset the lowest eligible port wins first.
        rr_chk = 1'b1; rr_mask = 4'b1110;
        for (int q = 1; q < NP; q++) begin
            push_beat(q, 32'(32'h2000 + q * 2),     1'b0, 0);
            push_beat(q, 32'(32'h2000 + q * 2 + 1), 1'b1, 0);
        end
        drain(4'b1110, 100, "post_reset");
        rr_chk = 1'b0;

        // Random packets from random ports under 50% backpressure.
        bp_en = 1'b1;
        total = 0;
        while (total < 1000) begin
            port = int'($urandom_range(0, NP - 1));
            len  = int'($urandom_range(1, 4));
            for (int k = 0; k < len; k++) begin
                push_beat(port, $urandom, 1'(k == len - 1), int'($urandom_range(0, 2)));
            end
            total += len;
        end
        drain(4'hF, 20000, "backpressure");
        bp_en = 1'b0;
        repeat (3) step();

        total = 0;
        for (int i = 0; i < NP; i++) total += exp_q[i].size();
        check("all_beats_delivered", 64'(total), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rr_arbiter.md
# axi_rr_arbiter

Packet-aware round-robin arbiter that shares one valid/ready stream among NUM_PORTS requesters, for example several DMA readers feeding a single frame-buffer write path. A grant is held for a whole packet, from the first beat through the beat with last set. The merged stream leaves through an internal register slice, so the output is fully registered and includes the source port ID.

## Interface
- NUM_PORTS, 4: number of requesters, 2..16.
- DATA_WIDTH, 32: payload width per beat.
- ID_WIDTH, derived: max(1, clog2(NUM_PORTS)); not overridable.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- port_en  in  NUM_PORTS  per-port eligibility mask; sampled only in ARB.
- in_data  in  NUM_PORTS*DATA_WIDTH  flattened payloads; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  in  NUM_PORTS  end-of-packet flag per port.
- in_valid  in  NUM_PORTS  beat valid per port.
- in_ready  out  NUM_PORTS  beat accepted per port.
- out_data  out  DATA_WIDTH  merged payload.
- out_last  out  1  end-of-packet.
- out_id  out  ID_WIDTH  source port of the current beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.

## Operation
- Two-state FSM: ARB and XFER. Reset state is ARB.
- **ARB:**
  - in_ready is all zero.
  - Eligible ports are in_valid & port_en.
  - If any port is eligible, pick the first one searching upward from (last_grant+1) mod NUM_PORTS. Register it in grant and last_grant, then go to XFER.
  - Otherwise stay in ARB.
- **XFER:**
  - in_ready[grant] = slice in_ready; every other in_ready bit is 0.
  - A handshake happens when in_valid[grant] & in_ready[grant]. The beat {grant, in_last[grant], payload} is pushed into the slice.
  - A handshake with last=1 returns the FSM to ARB on the next cycle.
  - Deasserting in_valid[grant] mid-packet does not release the grant; the arbiter waits indefinitely.
  - Clearing port_en mid-packet has no effect until the packet ends.
- A handshake is a transfer regardless of whether the other ports are requesting.
- **Reset:**
  - FSM goes to ARB, grant = 0, last_grant = NUM_PORTS-1, so port 0 has highest priority first.
  - The slice is cleared.
  - Outputs after reset: in_ready = 0, out_valid = 0, out_data = 0, out_last = 0, out_id = 0.
- **Reset mid-packet:** the partial packet is abandoned. Any beats held in the slice are dropped, and the downstream consumer must tolerate truncation.
- **Single-beat packets** (in_last=1 on the first beat) release after one beat.

## Timing
- Arbitration costs one cycle:
  - eligible in_valid at cycle N in ARB;
  - grant visible at N+1;
  - earliest handshake at N+1;
  - out_valid at N+2.
- Minimum occupancy of a packet of L beats is L+1 cycles, with one idle arbitration cycle between packets.
- Throughput inside a packet is one beat per cycle while out_ready=1.
- Backpressure:
  - The slice absorbs one extra beat.
  - in_ready falls at most one cycle after out_ready falls and out_valid is held.
  - No beat is lost or duplicated.
- The slice's in_ready is 0 during the first cycle after reset release. No handshake is possible before that cycle.
- out_* stay stable while out_valid=1 and out_ready=0.

## Structure
- Package axi_arb_pkg:
  - state enum {ARB, XFER};
  - function id_width(n) giving max(1, clog2(n));
  - function rr_pick(req, last) returning the next index plus a found flag.
- Sub-module: axi_slice with DATA_WIDTH = DATA_WIDTH+1+ID_WIDTH, carrying {id, last, data}. Its in_ready drives the granted port.
- The remaining logic is the FSM, the round-robin pointer and the input mux, all in this module.

## Test plan
- **Basic:** NUM_PORTS=4, port_en=4'hF, port 2 sends a 3-beat packet (data 0xA0..0xA2), out_ready=1 → out_valid from cycle N+2, beats in order, out_id=2, out_last only on 0xA2.
- **Fairness:** all 4 ports continuously send 2-beat packets → out_id sequence 0,1,2,3,0,… with one idle cycle between packets; no port starved over 64 packets.
- **Packet lock:** port 1 drops in_valid for 5 cycles mid-packet while port 3 requests → no port-3 beat appears until port 1's last beat has been transferred.
- **Backpressure:** random out_ready at 50% over 1000 beats from random ports → scoreboard matches per-port order, no loss or duplication; out_* stable while stalled.
- **Mask and reset:** port_en=4'b1010 with all ports valid → only IDs 1 and 3 are granted. Assert rstn=0 mid-packet for one cycle → next cycle out_valid=0, in_ready=0; first new grant goes to the lowest eligible port.
